// File: rtl/switch_conditioner.sv
// Switch input conditioning: two-flop synchroniser, per-channel debounce with
// rise/fall strobes, and an auto-repeat step pulse generated from one channel.
module switch_conditioner #(
    parameter int NBITS           = 8,
    parameter int DEBOUNCE_CYCLES = 4,
    parameter int REPEAT_DELAY    = 8,
    parameter int REPEAT_PERIOD   = 2,
    parameter int STEP_BIT        = 2
) (
    input  logic             clk_2,
    input  logic             reset,
    input  logic [NBITS-1:0] sw_raw,
    output logic [NBITS-1:0] sw_level,
    output logic [NBITS-1:0] sw_rise,
    output logic [NBITS-1:0] sw_fall,
    output logic             step_pulse,
    output logic             stable_all
);

    localparam int CW   = $clog2(DEBOUNCE_CYCLES + 1);
    localparam int TMAX = (REPEAT_DELAY > REPEAT_PERIOD) ? REPEAT_DELAY : REPEAT_PERIOD;
    localparam int TW   = $clog2(TMAX + 1);

    localparam logic [CW-1:0] CNT_LAST    = CW'(DEBOUNCE_CYCLES - 1);
    localparam logic [TW-1:0] DELAY_LAST  = TW'(REPEAT_DELAY - 1);
    localparam logic [TW-1:0] PERIOD_LAST = TW'(REPEAT_PERIOD - 1);

    typedef enum logic [1:0] {
        S_IDLE,
        S_DELAY,
        S_REPEAT
    } state_t;

    logic [NBITS-1:0]         r_sync1, r_sync2;
    logic [NBITS-1:0]         r_level, r_rise, r_fall;
    logic [NBITS-1:0][CW-1:0] r_cnt;
    logic                     r_step;
    logic [TW-1:0]            r_timer;
    state_t                   r_state;

    logic [NBITS-1:0]         w_level_next, w_rise_next, w_fall_next;
    logic [NBITS-1:0][CW-1:0] w_cnt_next;
    logic                     w_stable;
    logic                     w_step_next;
    logic                     w_release;
    logic [TW-1:0]            w_timer_next;
    state_t                   w_state_next;

    // NOTE: every always_comb output gets a default first, so no path can infer a latch.
    always_comb begin
        w_level_next = r_level;
        w_rise_next  = '0;
        w_fall_next  = '0;
        w_cnt_next   = '0;
        w_stable     = 1'b1;
        for (int i = 0; i < NBITS; i++) begin
            if (r_sync2[i] != r_level[i]) begin
                w_stable = 1'b0;
                if (r_cnt[i] == CNT_LAST) begin
                    w_level_next[i] = r_sync2[i];
                    w_rise_next[i]  = r_sync2[i];
                    w_fall_next[i]  = ~r_sync2[i];
                end else begin
                    w_cnt_next[i] = r_cnt[i] + 1'b1;
                end
            end else if (r_cnt[i] != '0) begin
                w_stable = 1'b0;
            end
        end
    end

    // Release is judged on the current level or a fall landing on this same edge.
    always_comb begin
        w_state_next = r_state;
        w_timer_next = r_timer;
        w_step_next  = 1'b0;
        w_release    = ~r_level[STEP_BIT] | w_fall_next[STEP_BIT];
        case (r_state)
            S_IDLE: begin
                if (w_rise_next[STEP_BIT]) begin
                    w_step_next  = 1'b1;
                    w_timer_next = '0;
                    w_state_next = S_DELAY;
                end
            end
            S_DELAY: begin
                if (w_release) begin
                    w_state_next = S_IDLE;
                end else if (r_timer == DELAY_LAST) begin
                    w_step_next  = 1'b1;
                    w_timer_next = '0;
                    w_state_next = S_REPEAT;
                end else begin
                    w_timer_next = r_timer + 1'b1;
                end
            end
            S_REPEAT: begin
                if (w_release) begin
                    w_state_next = S_IDLE;
                end else if (r_timer == PERIOD_LAST) begin
                    w_step_next  = 1'b1;
                    w_timer_next = '0;
                end else begin
                    w_timer_next = r_timer + 1'b1;
                end
            end
            default: w_state_next = S_IDLE;
        endcase
    end

    // NOTE: sequential state uses non-blocking assignments so all flops update together.
    always_ff @(posedge clk_2) begin
        if (reset) begin
            r_sync1 <= '0;
            r_sync2 <= '0;
            r_level <= '0;
            r_rise  <= '0;
            r_fall  <= '0;
            r_cnt   <= '0;
            r_step  <= 1'b0;
            r_timer <= '0;
            r_state <= S_IDLE;
        end else begin
            r_sync1 <= sw_raw;
            r_sync2 <= r_sync1;
            r_level <= w_level_next;
            r_rise  <= w_rise_next;
            r_fall  <= w_fall_next;
            r_cnt   <= w_cnt_next;
            r_step  <= w_step_next;
            r_timer <= w_timer_next;
            r_state <= w_state_next;
        end
    end

    assign sw_level   = r_level;
    assign sw_rise    = r_rise;
    assign sw_fall    = r_fall;
    assign step_pulse = r_step;
    assign stable_all = w_stable;

endmodule

// File: tb/tb_switch_conditioner.sv
// Bench for switch_conditioner: directed scenarios plus randomized switch
// activity, all compared against a cycle-level behavioural model.
module tb_switch_conditioner;

    localparam int NB = 8;
    localparam int DB = 4;
    localparam int RD = 8;
    localparam int RP = 2;
    localparam int SB = 2;

    logic          clk_2 = 1'b0;
    logic          reset;
    logic [NB-1:0] sw_raw;
    logic [NB-1:0] sw_level, sw_rise, sw_fall;
    logic          step_pulse, stable_all;

    int checks = 0;
    int errors = 0;
    int cyc    = 0;

    // Behavioural model state
    logic [NB-1:0] m_s1, m_s2, m_level, m_rise, m_fall;
    int            m_run [NB];
    logic          m_step, m_stable, m_active;
    int            m_t0;

    switch_conditioner #(
        .NBITS(NB), .DEBOUNCE_CYCLES(DB), .REPEAT_DELAY(RD),
        .REPEAT_PERIOD(RP), .STEP_BIT(SB)
    ) dut (
        .clk_2(clk_2), .reset(reset), .sw_raw(sw_raw),
        .sw_level(sw_level), .sw_rise(sw_rise), .sw_fall(sw_fall),
        .step_pulse(step_pulse), .stable_all(stable_all)
    );

    always #5 clk_2 = ~clk_2;

    // Level flips once the synchronised input has disagreed for DB straight
    // cycles; the step train fires at offsets 0, RD, RD+RP, ... from its start.
    task automatic model_step(input logic rst, input logic [NB-1:0] raw);
        logic [NB-1:0] old_s2, old_level;
        int k;
        if (rst) begin
            m_s1 = '0; m_s2 = '0; m_level = '0; m_rise = '0; m_fall = '0;
            for (int i = 0; i < NB; i++) m_run[i] = 0;
            m_step = 1'b0; m_active = 1'b0; m_t0 = 0;
        end else begin
            old_s2    = m_s2;
            old_level = m_level;
            m_s2 = m_s1;
            m_s1 = raw;
            m_rise = '0;
            m_fall = '0;
            for (int i = 0; i < NB; i++) begin
                if (old_s2[i] != old_level[i]) begin
                    m_run[i]++;
                    if (m_run[i] == DB) begin
                        m_level[i] = old_s2[i];
                        if (old_s2[i]) m_rise[i] = 1'b1;
                        else           m_fall[i] = 1'b1;
                        m_run[i] = 0;
                    end
                end else begin
                    m_run[i] = 0;
                end
            end
            m_step = 1'b0;
            if (!m_active) begin
                if (m_rise[SB]) begin
                    m_step = 1'b1; m_active = 1'b1; m_t0 = cyc;
                end
            end else if (!old_level[SB] || m_fall[SB]) begin
                m_active = 1'b0;
            end else begin
                k = cyc - m_t0;
                if (k == RD || (k > RD && (k - RD) % RP == 0)) m_step = 1'b1;
            end
        end
        m_stable = 1'b1;
        for (int i = 0; i < NB; i++)
            if (m_s2[i] != m_level[i] || m_run[i] != 0) m_stable = 1'b0;
    endtask

    task automatic tick(input logic rst, input logic [NB-1:0] raw);
        reset  = rst;
        sw_raw = raw;
        @(posedge clk_2);
        cyc++;
        model_step(rst, raw);
        #1;
    endtask

    function automatic logic [3*NB+1:0] dut_bundle();
        return {sw_level, sw_rise, sw_fall, step_pulse, stable_all};
    endfunction

    function automatic logic [3*NB+1:0] model_bundle();
        return {m_level, m_rise, m_fall, m_step, m_stable};
    endfunction

    task automatic test_reset();
        tick(1'b1, 8'hA5);
        checks++;
        if (dut_bundle() !== {{(3*NB+1){1'b0}}, 1'b1}) begin
            errors++; $display("FAIL reset_state: got %h exp %h", dut_bundle(), {{(3*NB+1){1'b0}}, 1'b1});
        end
        for (int n = 1; n <= 10; n++) begin
            tick(1'b0, 8'h00);
            checks++;
            if ({sw_level, sw_rise, sw_fall, step_pulse} !== '0 || stable_all !== 1'b1) begin
                errors++; $display("FAIL idle_zero n=%0d: got %h exp all-zero stable=1", n, dut_bundle());
            end
        end
    endtask

    task automatic test_debounce_latency();
        for (int n = 1; n <= 9; n++) begin
            tick(1'b0, 8'h01);
            checks++;
            if (sw_level[0] !== (n >= 6) || sw_rise[0] !== (n == 6) || stable_all !== !(n >= 2 && n <= 5)) begin
                errors++;
                $display("FAIL debounce_latency edge=%0d: level=%b rise=%b stable=%b exp %b %b %b",
                         n, sw_level[0], sw_rise[0], stable_all, n >= 6, n == 6, !(n >= 2 && n <= 5));
            end
            checks++;
            if (dut_bundle() !== model_bundle()) begin
                errors++; $display("FAIL debounce_model edge=%0d: got %h exp %h", n, dut_bundle(), model_bundle());
            end
        end
    endtask

    task automatic test_glitch();
        for (int n = 1; n <= 12; n++) begin
            tick(1'b0, (n <= 3) ? 8'h03 : 8'h01);
            checks++;
            if (sw_level[1] !== 1'b0 || sw_rise[1] !== 1'b0 || sw_fall[1] !== 1'b0) begin
                errors++; $display("FAIL glitch n=%0d: level/rise/fall=%b%b%b exp 000", n, sw_level[1], sw_rise[1], sw_fall[1]);
            end
        end
    endtask

    task automatic test_step_repeat();
        int  falls;
        bit  fell;
        bit  exp_step;
        for (int n = 1; n <= 30; n++) begin
            tick(1'b0, 8'h05);
            exp_step = (n == 6) || (n >= 6 + RD && (n - 6 - RD) % RP == 0);
            checks++;
            if (step_pulse !== exp_step || sw_rise[SB] !== (n == 6)) begin
                errors++;
                $display("FAIL step_train n=%0d: step=%b rise=%b exp %b %b", n, step_pulse, sw_rise[SB], exp_step, n == 6);
            end
        end
        falls = 0;
        fell  = 1'b0;
        for (int m = 1; m <= 12; m++) begin
            tick(1'b0, 8'h01);
            if (sw_fall[SB]) begin falls++; fell = 1'b1; end
            checks++;
            if (dut_bundle() !== model_bundle()) begin
                errors++; $display("FAIL release_model m=%0d: got %h exp %h", m, dut_bundle(), model_bundle());
            end
            if (fell) begin
                checks++;
                if (step_pulse !== 1'b0) begin
                    errors++; $display("FAIL step_after_release m=%0d: got %b exp 0", m, step_pulse);
                end
            end
        end
        checks++;
        if (falls != 1) begin
            errors++; $display("FAIL release_fall_count: got %0d exp 1", falls);
        end
    endtask

    task automatic test_all_channels();
        for (int n = 1; n <= 10; n++) tick(1'b0, 8'h00);
        checks++;
        if (sw_level !== 8'h00 || stable_all !== 1'b1) begin
            errors++; $display("FAIL all_clear: level=%h stable=%b exp 00 1", sw_level, stable_all);
        end
        for (int n = 1; n <= 6; n++) begin
            tick(1'b0, 8'hFF);
            checks++;
            if (sw_rise !== ((n == 6) ? 8'hFF : 8'h00) || sw_level !== ((n == 6) ? 8'hFF : 8'h00) || step_pulse !== (n == 6)) begin
                errors++;
                $display("FAIL all_rise edge=%0d: level=%h rise=%h step=%b", n, sw_level, sw_rise, step_pulse);
            end
        end
        for (int n = 7; n <= 16; n++) begin
            tick(1'b0, 8'hFF);
            checks++;
            if (dut_bundle() !== model_bundle()) begin
                errors++; $display("FAIL all_hold edge=%0d: got %h exp %h", n, dut_bundle(), model_bundle());
            end
        end
    endtask

    task automatic test_reset_mid_repeat();
        tick(1'b1, 8'hFF);
        checks++;
        if ({sw_level, sw_rise, sw_fall, step_pulse} !== '0) begin
            errors++; $display("FAIL reset_mid_repeat: got %h exp 0", dut_bundle());
        end
        for (int n = 1; n <= 8; n++) begin
            tick(1'b0, 8'hFF);
            checks++;
            if (sw_rise !== ((n == DB + 2) ? 8'hFF : 8'h00) || step_pulse !== (n == DB + 2)) begin
                errors++;
                $display("FAIL post_reset_rise edge=%0d: rise=%h step=%b", n, sw_rise, step_pulse);
            end
        end
    endtask

    task automatic test_random();
        logic [NB-1:0] raw;
        logic          rst;
        raw = 8'hFF;
        for (int n = 0; n < 600; n++) begin
            for (int i = 0; i < NB; i++) begin
                if (i == SB) begin
                    if ($urandom_range(0, 39) == 0) raw[i] = ~raw[i];
                end else if ($urandom_range(0, 7) == 0) begin
                    raw[i] = ~raw[i];
                end
            end
            rst = ($urandom_range(0, 149) == 0);
            tick(rst, raw);
            checks++;
            if (dut_bundle() !== model_bundle()) begin
                errors++; $display("FAIL random n=%0d: got %h exp %h", n, dut_bundle(), model_bundle());
            end
        end
    endtask

    initial begin
        reset  = 1'b1;
        sw_raw = '0;
        tick(1'b1, 8'h00);
        test_reset();
        test_debounce_latency();
        test_glitch();
        test_step_repeat();
        test_all_channels();
        test_reset_mid_repeat();
        test_random();
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule

// File: doc/switch_conditioner.md
Name: switch_conditioner

Overview:
Input-conditioning stage between the raw board switches (SWI) and the 4-bit hex up/down counter.
- Synchronises every switch into the clk_2 domain and debounces it.
- Emits clean levels plus single-cycle rise and fall pulses.
- Generates an auto-repeat step pulse from one designated switch.
- The counter consumes sw_level[0] as its reset, sw_level[1] as its direction and step_pulse as its count enable.

Parameters:
- NBITS, 8: number of switch channels.
- DEBOUNCE_CYCLES, 4: consecutive cycles a synchronised input must differ from sw_level before sw_level updates; must be >= 1.
- REPEAT_DELAY, 8: cycles from the first step pulse to the first auto-repeat pulse; must be >= 1.
- REPEAT_PERIOD, 2: cycles between consecutive auto-repeat pulses; must be >= 1.
- STEP_BIT, 2: channel index that drives step_pulse; must be < NBITS.

Ports:
- clk_2, input, 1: system clock; all state updates on its rising edge.
- reset, input, 1: synchronous, active-high.
- sw_raw, input, NBITS: asynchronous raw switch inputs.
- sw_level, output, NBITS: debounced switch levels (registered).
- sw_rise, output, NBITS: one-cycle pulse per channel when sw_level goes 0->1 (registered).
- sw_fall, output, NBITS: one-cycle pulse per channel when sw_level goes 1->0 (registered).
- step_pulse, output, 1: one-cycle step strobe with auto-repeat (registered).
- stable_all, output, 1: combinational; 1 when every channel has sync2 == sw_level and debounce counter == 0.

Behaviour:
- Reset (synchronous, active-high; clock clk_2):
  - sync1, sync2, sw_level, sw_rise, sw_fall, all debounce counters, step_pulse, the FSM timer -> 0.
  - FSM -> IDLE.
  - Takes effect at the next edge, even mid-debounce or mid-repeat; no pulse is emitted on that edge.
- Synchroniser, per channel: sync1 <= sw_raw[i]; sync2 <= sync1.
- Debounce, per channel, counter width $clog2(DEBOUNCE_CYCLES+1):
  - If sync2 == sw_level[i]: cnt <= 0.
  - Else if cnt == DEBOUNCE_CYCLES-1: sw_level[i] <= sync2, cnt <= 0, and sw_rise[i] or sw_fall[i] <= 1 on this edge.
  - Else: cnt <= cnt+1.
  - sw_rise and sw_fall are 0 on every other edge. Pulses are exactly one cycle and coincide with the cycle in which the new sw_level is visible.
- Debounce latency: sw_raw is first sampled at edge 1 and held stable; sw_level changes after edge DEBOUNCE_CYCLES+2 (edge 6 at default).
- Glitch rejection: a sync2 deviation shorter than DEBOUNCE_CYCLES cycles resets cnt and produces no level change and no pulse.
- Channels are fully independent; simultaneous transitions on several channels each produce their own pulses in the same cycle.
- Step FSM, driven by channel STEP_BIT, timer width $clog2(max(REPEAT_DELAY, REPEAT_PERIOD)+1). step_pulse defaults to 0 on every edge unless set below.
  - IDLE: when sw_rise[STEP_BIT] is being set on this edge -> step_pulse <= 1, timer <= 0, go to DELAY.
  - DELAY:
    - If sw_level[STEP_BIT]==0 or sw_fall[STEP_BIT] is being set -> IDLE, no pulse.
    - Else if timer == REPEAT_DELAY-1 -> step_pulse <= 1, timer <= 0, go to REPEAT.
    - Else timer <= timer+1.
  - REPEAT:
    - Same release check as DELAY -> IDLE.
    - Else if timer == REPEAT_PERIOD-1 -> step_pulse <= 1, timer <= 0.
    - Else timer <= timer+1.
  - Resulting pulse train: if the first pulse is at cycle T, later pulses are at T+REPEAT_DELAY, then every REPEAT_PERIOD cycles until release.
  - Release on the same edge a repeat would fire: release wins, no pulse.
- Wrap-around: counters never exceed their terminal value; there is no overflow path.

Test Plan:
1. Reset, then sw_raw=8'h00 held for 10 cycles -> all outputs 0, stable_all=1.
2. sw_raw[0] 0->1 held, DEBOUNCE_CYCLES=4 -> sw_level[0]=1 and sw_rise[0]=1 after edge 6 for exactly one cycle; stable_all=0 during edges 2..5, then 1.
3. sw_raw[1] pulsed high for 3 cycles only -> sw_level[1], sw_rise[1], sw_fall[1] stay 0 throughout.
4. sw_raw[2] held high for 30 cycles with REPEAT_DELAY=8, REPEAT_PERIOD=2 -> step_pulse at cycle T (with sw_rise[2]), T+8, T+10, T+12, ...
   - After release, one sw_fall[2] pulse and no further step_pulse.
5. sw_raw=8'hFF applied in one cycle -> all 8 sw_level bits and 8 sw_rise bits assert on the same edge 6; step_pulse asserts on that edge too.
6. reset asserted while in REPEAT with sw_level=8'hFF -> next cycle all outputs 0, FSM IDLE.
   - After reset is released with sw_raw still 8'hFF, sw_rise=8'hFF reappears after DEBOUNCE_CYCLES+2 edges.
